// File: rtl/aes_host_bridge.sv
// aes_host_bridge: word-oriented host front end for the AES_top core.
// The host writes a 128-bit plaintext and key as 32-bit words and pulses start.
// The bridge holds AES_en for EN_HOLD_CYCLES, then waits up to TIMEOUT_CYCLES
// for AES_data_out_valid. The captured result is returned MSW first as four
// 32-bit words on a valid/ready stream.
// Ports:
//   AES_clk, AES_rst            clock, async active-high reset
//   wr_en/wr_addr/wr_data       host register writes (0-3 plaintext, 4-7 key)
//   start                       one-cycle request to run an encryption
//   busy, timeout               status (timeout is sticky until next start)
//   rd_valid/rd_ready/rd_data/rd_last  result word stream
//   AES_en/AES_data_in/AES_key_in      stimulus to the core
//   AES_data_out/AES_data_out_valid    response from the core
module aes_host_bridge #(
  parameter int unsigned EN_HOLD_CYCLES = 51,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         start,
  output logic         busy,
  output logic         timeout,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [31:0]  rd_data,
  output logic         rd_last,
  output logic         AES_en,
  output logic [127:0] AES_data_in,
  output logic [127:0] AES_key_in,
  input  logic [127:0] AES_data_out,
  input  logic         AES_data_out_valid
);

  localparam int unsigned HOLD_W = (EN_HOLD_CYCLES > 1) ? $clog2(EN_HOLD_CYCLES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EN_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DRAIN} state_t;

  state_t              state, state_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic [TO_W-1:0]     to_cnt, to_nx;
  logic [1:0]          word_idx, idx_nx;
  logic                captured, cap_nx;
  logic [127:0]        result, result_nx;
  logic [127:0]        data_nx, key_nx;
  logic                timeout_nx, aes_en_nx, busy_nx, rd_valid_nx, rd_last_nx;
  logic [31:0]         rd_data_nx;
  logic                capture_c;
  logic [127:0]        cap_val_c;

  // Next-state, datapath and registered-output values
  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    to_nx      = to_cnt;
    idx_nx     = word_idx;
    cap_nx     = captured;
    result_nx  = result;
    data_nx    = AES_data_in;
    key_nx     = AES_key_in;
    timeout_nx = timeout;

    // Only the first valid of an operation is taken, and only while the core is active
    capture_c = ((state == RUN) || (state == WAIT)) && AES_data_out_valid && !captured;
    // Result as seen after this edge, so the first DRAIN word is correct on entry
    cap_val_c = capture_c ? AES_data_out : result;
    if (capture_c) begin
      result_nx = AES_data_out;
      cap_nx    = 1'b1;
    end

    case (state)
      IDLE: begin
        if (wr_en) begin
          if (wr_addr[2]) key_nx[{~wr_addr[1:0], 5'd0} +: 32] = wr_data;
          else            data_nx[{~wr_addr[1:0], 5'd0} +: 32] = wr_data;
        end
        if (start) begin
          state_nx   = RUN;
          hold_nx    = '0;
          to_nx      = '0;
          idx_nx     = '0;
          cap_nx     = 1'b0;
          timeout_nx = 1'b0;
        end
      end
      RUN: begin
        if (hold_cnt == HOLD_LAST) state_nx = (captured || capture_c) ? DRAIN : WAIT;
        else                       hold_nx  = hold_cnt + HOLD_W'(1);
      end
      WAIT: begin
        // Capture takes priority over a same-cycle timeout expiry
        if (capture_c) begin
          state_nx = DRAIN;
        end else if (to_cnt == TO_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          to_nx = to_cnt + TO_W'(1);
        end
      end
      DRAIN: begin
        if (rd_valid && rd_ready) begin
          if (word_idx == 2'd3) state_nx = IDLE;
          else                  idx_nx   = word_idx + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    aes_en_nx   = (state_nx == RUN);
    busy_nx     = (state_nx != IDLE);
    rd_valid_nx = (state_nx == DRAIN);
    rd_last_nx  = (state_nx == DRAIN) && (idx_nx == 2'd3);
    rd_data_nx  = (state_nx == DRAIN) ? cap_val_c[{~idx_nx, 5'd0} +: 32] : 32'h0;
  end

  // State, datapath and output registers
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      word_idx    <= '0;
      captured    <= 1'b0;
      result      <= '0;
      AES_data_in <= '0;
      AES_key_in  <= '0;
      timeout     <= 1'b0;
      AES_en      <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_data     <= '0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      to_cnt      <= to_nx;
      word_idx    <= idx_nx;
      captured    <= cap_nx;
      result      <= result_nx;
      AES_data_in <= data_nx;
      AES_key_in  <= key_nx;
      timeout     <= timeout_nx;
      AES_en      <= aes_en_nx;
      busy        <= busy_nx;
      rd_valid    <= rd_valid_nx;
      rd_last     <= rd_last_nx;
      rd_data     <= rd_data_nx;
    end
  end

endmodule

// File: tb/tb_aes_host_bridge.sv
// tb_aes_host_bridge: directed self-checking bench for aes_host_bridge with a
// small AES_top stub that pulses AES_data_out_valid at a chosen cycle of the operation.
module tb_aes_host_bridge;

  logic         AES_clk;
  logic         AES_rst;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         start;
  logic         busy;
  logic         timeout;
  logic         rd_valid;
  logic         rd_ready;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Stub configuration (written only by the main initial block)
  int           stub_at1 = -1;
  int           stub_at2 = -1;
  logic [127:0] stub_data1 = '0;
  logic [127:0] stub_data2 = '0;
  int           stub_cnt = 0;
  int           en_cnt = 0;

  localparam logic [127:0] PT   = 128'h0000009b_00000000_00000000_00000000;
  localparam logic [127:0] KEY  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] RES  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] RES2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] JUNK = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;

  aes_host_bridge #(.EN_HOLD_CYCLES(51), .TIMEOUT_CYCLES(255)) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .start              (start),
    .busy               (busy),
    .timeout            (timeout),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_data            (rd_data),
    .rd_last            (rd_last),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  // Core stub: cycle N of an operation is the cycle sampled at start edge + N
  always @(negedge AES_clk) begin
    stub_cnt = busy ? stub_cnt + 1 : 0;
    AES_data_out_valid = (stub_cnt == stub_at1) || (stub_cnt == stub_at2);
    AES_data_out = (stub_cnt == stub_at2) ? stub_data2 : stub_data1;
  end

  always @(negedge AES_clk) if (AES_en) en_cnt = en_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [2:0] addr, input logic [31:0] data);
    @(negedge AES_clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge AES_clk);
    wr_en = 1'b0;
  endtask

  task automatic load_regs(input logic [127:0] pt, input logic [127:0] key);
    for (int i = 0; i < 4; i++) begin
      write_word(3'(i), pt[(3 - i) * 32 +: 32]);
      write_word(3'(i + 4), key[(3 - i) * 32 +: 32]);
    end
  endtask

  // Returns just after the start edge
  task automatic pulse_start();
    @(negedge AES_clk);
    start = 1'b1;
    @(posedge AES_clk);
    #1 start = 1'b0;
  endtask

  // Reads four words; first_n counts negedges from the start edge to first rd_valid
  task automatic drain(input logic [127:0] exp, input int stall_idx, output int first_n);
    int idx;
    int n;
    logic [31:0] w;
    idx = 0; n = 0; first_n = -1;
    while (idx < 4 && n < 1000) begin
      @(negedge AES_clk);
      n++;
      if (rd_valid) begin
        if (first_n < 0) first_n = n;
        w = exp[(3 - idx) * 32 +: 32];
        if (idx == stall_idx) begin
          for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge AES_clk);
            check_eq("stall_hold", 128'(rd_data), 128'(w));
            check_eq("stall_valid", 128'(rd_valid), 128'(1'b1));
            wr_en   = (i == 0) || (i == 1);
            wr_addr = (i == 0) ? 3'd0 : 3'd5;
            wr_data = (i == 0) ? 32'hdeadbeef : 32'hcafef00d;
            start   = (i == 2);
          end
          @(negedge AES_clk);
          wr_en = 1'b0; start = 1'b0;
        end
        check_eq($sformatf("word%0d", idx), 128'(rd_data), 128'(w));
        check_eq($sformatf("last%0d", idx), 128'(rd_last), 128'(idx == 3));
        rd_ready = 1'b1;
        @(posedge AES_clk);
        #1 rd_ready = 1'b0;
        idx++;
      end
    end
    check_eq("drain_words", 128'(idx), 128'(4));
  endtask

  int first_n;
  int en_base;
  int n;
  logic saw_rv;

  initial begin
    AES_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; rd_ready = 1'b0;
    AES_data_out = '0; AES_data_out_valid = 1'b0;
    repeat (3) @(negedge AES_clk);
    check_eq("rst_en", 128'(AES_en), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_timeout", 128'(timeout), 128'(0));
    check_eq("rst_rd_valid", 128'(rd_valid), 128'(0));
    check_eq("rst_rd_last", 128'(rd_last), 128'(0));
    check_eq("rst_rd_data", 128'(rd_data), 128'(0));
    check_eq("rst_data_in", AES_data_in, 128'h0);
    check_eq("rst_key_in", AES_key_in, 128'h0);
    AES_rst = 1'b0;

    // Basic operation, result arrives during WAIT
    load_regs(PT, KEY);
    check_eq("data_in", AES_data_in, PT);
    check_eq("key_in", AES_key_in, KEY);
    stub_at1 = 60; stub_data1 = RES;
    pulse_start();
    en_base = en_cnt;
    check_eq("run_en", 128'(AES_en), 128'(1));
    check_eq("run_busy", 128'(busy), 128'(1));
    drain(RES, -1, first_n);
    check_eq("t1_latency", 128'(first_n), 128'(61));
    check_eq("t1_en_cycles", 128'(en_cnt - en_base), 128'(51));
    check_eq("t1_timeout", 128'(timeout), 128'(0));
    check_eq("t1_busy_done", 128'(busy), 128'(0));
    check_eq("t1_data_in", AES_data_in, PT);
    check_eq("t1_key_in", AES_key_in, KEY);

    // Result during RUN; a later valid in the same operation is ignored
    stub_at1 = 10; stub_data1 = RES2; stub_at2 = 30; stub_data2 = JUNK;
    pulse_start();
    en_base = en_cnt;
    drain(RES2, -1, first_n);
    check_eq("t2_latency", 128'(first_n), 128'(52));
    check_eq("t2_en_cycles", 128'(en_cnt - en_base), 128'(51));
    stub_at2 = -1;

    // No valid: timeout after 51+255 cycles
    stub_at1 = -1;
    pulse_start();
    en_base = en_cnt;
    n = 0; saw_rv = 1'b0;
    while (busy && n < 1000) begin
      @(negedge AES_clk);
      n++;
      saw_rv = saw_rv | rd_valid;
    end
    check_eq("t3_latency", 128'(n), 128'(307));
    check_eq("t3_timeout", 128'(timeout), 128'(1));
    check_eq("t3_busy", 128'(busy), 128'(0));
    check_eq("t3_no_rd_valid", 128'(saw_rv), 128'(0));
    check_eq("t3_en_cycles", 128'(en_cnt - en_base), 128'(51));
    stub_at1 = 60; stub_data1 = RES;
    pulse_start();
    check_eq("t3_timeout_clr", 128'(timeout), 128'(0));
    drain(RES, -1, first_n);

    // Back-pressure on word 2 with writes and start during DRAIN
    pulse_start();
    drain(RES, 2, first_n);
    check_eq("t4_data_in", AES_data_in, PT);
    check_eq("t4_key_in", AES_key_in, KEY);
    repeat (3) @(negedge AES_clk);
    check_eq("t4_no_restart", 128'(busy), 128'(0));

    // Reset in the middle of RUN
    pulse_start();
    repeat (20) @(negedge AES_clk);
    AES_rst = 1'b1;
    #1;
    check_eq("t5_en", 128'(AES_en), 128'(0));
    check_eq("t5_busy", 128'(busy), 128'(0));
    check_eq("t5_rd_valid", 128'(rd_valid), 128'(0));
    check_eq("t5_data_in", AES_data_in, 128'h0);
    check_eq("t5_key_in", AES_key_in, 128'h0);
    repeat (2) @(negedge AES_clk);
    AES_rst = 1'b0;
    load_regs(PT, KEY);
    pulse_start();
    drain(RES, -1, first_n);
    check_eq("t5_latency", 128'(first_n), 128'(61));

    // Write and start in the same IDLE cycle
    @(negedge AES_clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'ha6f2daeb; start = 1'b1;
    @(posedge AES_clk);
    #1 wr_en = 1'b0; start = 1'b0;
    repeat (3) @(negedge AES_clk);
    check_eq("t6_en", 128'(AES_en), 128'(1));
    check_eq("t6_data_msw", 128'(AES_data_in[127:96]), 128'(32'ha6f2daeb));
    drain(RES, -1, first_n);
    check_eq("t6_key_in", AES_key_in, KEY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_host_bridge.md
# aes_host_bridge

Word-oriented host front end for the AES_top encryption core. It collects a 128-bit plaintext and a 128-bit key as 32-bit register writes, then drives the core's AES_en / AES_data_in / AES_key_in stimulus protocol. It captures AES_data_out on AES_data_out_valid and returns the result to the host as four 32-bit words over a valid/ready stream. It sits between the system bus and AES_top and is the initiator for the core's responder interface.

## Interface
- EN_HOLD_CYCLES, 51: cycles AES_en is held high per operation (≥1).
- TIMEOUT_CYCLES, 255: post-hold cycles to wait for AES_data_out_valid (≥1).
- AES_clk  in  1  single clock, rising edge.
- AES_rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  host register write strobe.
- wr_addr  in  3  0–3 = plaintext words, 4–7 = key words.
- wr_data  in  32  write data.
- start  in  1  one-cycle request to run an encryption.
- busy  out  1  operation in progress (RUN, WAIT or DRAIN).
- timeout  out  1  sticky: last operation got no valid within the timeout.
- rd_valid  out  1  result word available.
- rd_ready  in  1  host accepts result word.
- rd_data  out  32  result word.
- rd_last  out  1  marks the fourth result word.
- AES_en  out  1  core enable.
- AES_data_in  out  128  plaintext to core.
- AES_key_in  out  128  key to core.
- AES_data_out  in  128  core result.
- AES_data_out_valid  in  1  core result valid.

## Operation
- Word order: address 0 maps to bits [127:96] and address 3 to [31:0]. Addresses 4–7 map the key the same way.
- AES_data_in and AES_key_in are driven directly from the holding registers. They stay stable except on writes accepted in IDLE.
- Writes are accepted only in IDLE and ignored otherwise. start outside IDLE is ignored.
- wr_en and start in the same IDLE cycle: the write lands on that edge, so the operation uses the new value.
- FSM states are IDLE, RUN, WAIT and DRAIN.
  - IDLE → RUN on start. The same edge clears timeout, the capture flag and both counters.
  - RUN: AES_en=1. The hold counter counts EN_HOLD_CYCLES cycles. At expiry, go to DRAIN if a result was captured, otherwise go to WAIT.
  - WAIT: AES_en=0. The timeout counter increments each cycle. Valid goes to DRAIN. Reaching TIMEOUT_CYCLES without valid sets timeout and goes to IDLE.
  - DRAIN: presents 4 words, MSW first (result[127:96]). The word index advances on rd_valid&rd_ready. rd_last=1 at index 3. The handshake on index 3 goes to IDLE.
- Capture: the first cycle in RUN or WAIT with AES_data_out_valid=1 latches AES_data_out into the result register and sets the capture flag. Later valids in the same operation are ignored.
- Valid in IDLE or DRAIN is ignored.
- Valid on the same cycle as timeout expiry: capture wins, go to DRAIN, timeout stays 0.

## Timing
- Reset (asynchronous, immediate) sets:
  - all outputs to 0: AES_en, busy, timeout, rd_valid, rd_last, rd_data;
  - AES_data_in and AES_key_in to 128'h0;
  - all counters and the result register to 0;
  - state to IDLE.
- Reset mid-operation drops AES_en within the same cycle. No result is emitted.
- start sampled at edge k: AES_en and busy are high from edge k through edge k+EN_HOLD_CYCLES. That is exactly EN_HOLD_CYCLES cycles.
- Capture at edge m with the FSM entering DRAIN at that edge: rd_valid is high after edge m.
- Capture during RUN: rd_valid is high after the hold-expiry edge.
- rd_data and rd_last hold steady while rd_valid&!rd_ready. rd_valid stays high until the fourth word is accepted.
- busy deasserts on the edge leaving DRAIN or on timeout. A new start is accepted on the following cycle.
- Counters are wide enough for their parameters and never wrap within one operation.

## Test plan
- Setup: write data 0000009b_00000000_00000000_00000000 and key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, then start. The core stub returns 128'h00112233_44556677_8899aabb_ccddeeff with valid at cycle 60.
  - Required: AES_en high exactly 51 cycles.
  - Required: AES_data_in and AES_key_in equal the written values.
  - Required: words 00112233, 44556677, 8899aabb, ccddeeff, with rd_last on the last.
- Stub asserts valid at cycle 10 of RUN → AES_en still held the full 51 cycles; rd_valid rises after hold expiry with the cycle-10 data.
- Stub never asserts valid → timeout=1 exactly 51+255 cycles after start; busy=0; rd_valid never asserted. The next start clears timeout.
- rd_ready low for 5 cycles on word 2, plus writes and start during DRAIN → rd_data is held; the writes and start are ignored; registers are unchanged.
- AES_rst pulse at cycle 20 of RUN → AES_en=0 immediately; all outputs 0; a fresh operation after reset completes normally.
- Same-cycle wr_en (addr 0, 0xa6f2daeb) and start → AES_data_in[127:96]=a6f2daeb while AES_en is high.
